fifo: RTL and testbench



---
 rtl/fifo.sv | 65 ++++++
 tb/tb_fifo.sv | 104 ++++++++++
 2 files changed

// File: rtl/fifo.sv
// fifo: single-clock show-ahead circular buffer with full/empty flags and synchronous flush
module fifo #(
   parameter int data_width = 32,
   parameter int size       = 32,
   parameter int device_id  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [data_width-1:0] data_in,
   input  logic                  insert,
   input  logic                  next,
   input  logic                  clear,
   output logic [data_width-1:0] data_out,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = (size > 1) ? $clog2(size) : 1;
   localparam int CW = $clog2(size + 1);
   localparam logic [AW-1:0] LAST = AW'(size - 1);
   localparam logic [CW-1:0] CAP  = CW'(size);

   logic [data_width-1:0] mem [0:size-1];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         words_inside, words_inside_d;
   logic                  push, pop;
   logic [31:0]           unused_device_id;

   // device_id only tags diagnostics; it has no hardware meaning
   assign unused_device_id = device_id;

   // flags and head word decode straight from registered state, never from the inputs
   assign full     = words_inside == CAP;
   assign empty    = words_inside == '0;
   assign data_out = empty ? '0 : mem[rd_ptr_q];

   // accept decisions and next state; clear wins, a full queue still takes a word when it is popping
   always_comb begin
      push           = !clear && insert && (!full || next);
      pop            = !clear && next && !empty;
      wr_ptr_d       = clear ? '0 : push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d       = clear ? '0 : pop ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      words_inside_d = clear ? '0
                     : (push && !pop) ? words_inside + 1'b1
                     : (pop && !push) ? words_inside - 1'b1
                     : words_inside;
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         words_inside <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         words_inside <= words_inside_d;
      end
   end

   // storage is not reset; stale contents are hidden by the occupancy count
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= data_in;
   end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed test-plan scenarios plus random traffic against a queue model
module tb_fifo;
   localparam int DW = 32;
   localparam int SZ = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          insert = 1'b0;
   logic          next = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] data_out;
   logic          full, empty;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model_q[$];

   fifo #(.data_width(DW), .size(SZ), .device_id(7)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .insert(insert),
      .next(next), .clear(clear), .data_out(data_out), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data_out"}, data_out, model_q.size() != 0 ? model_q[0] : '0);
      check({tag, ".full"}, DW'(full), DW'(model_q.size() == SZ));
      check({tag, ".empty"}, DW'(empty), DW'(model_q.size() == 0));
      check({tag, ".count"}, DW'(dut.words_inside), DW'(model_q.size()));
   endtask

   // drive one cycle from a falling edge, apply the model at the rising edge, look at the next falling edge
   task automatic step(input logic ins, input logic nxt, input logic clr, input logic [DW-1:0] din, input string tag);
      bit was_full, was_empty;
      insert  = ins;
      next    = nxt;
      clear   = clr;
      data_in = din;
      @(posedge clk);
      was_full  = model_q.size() == SZ;
      was_empty = model_q.size() == 0;
      if (clr) model_q.delete();
      else begin
         if (nxt && !was_empty) void'(model_q.pop_front());
         if (ins && (!was_full || nxt)) model_q.push_back(din);
      end
      @(negedge clk);
      insert = 1'b0;
      next   = 1'b0;
      clear  = 1'b0;
      check_all(tag);
   endtask

   initial begin
      #1 check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) step(1, 0, 0, DW'(i * 'h11), "fill");
      check("fill.full_const", DW'(full), 1);
      step(1, 0, 0, 'h55, "overflow");
      check("overflow.head", data_out, 'h11);
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, "drain");
      check("drain.out_zero", data_out, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 'hA0 + DW'(i), "wrap.push3");
      for (int i = 0; i < 2; i++) step(0, 1, 0, '0, "wrap.pop2");
      for (int i = 0; i < 3; i++) step(1, 0, 0, 'hB0 + DW'(i), "wrap.push3b");
      check("wrap.head", data_out, 'hA2);
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, "wrap.pop4");
      step(1, 1, 0, 'h77, "simul.empty");
      check("simul.empty.out", data_out, 'h77);
      step(0, 1, 0, '0, "simul.pop");
      for (int i = 1; i <= 4; i++) step(1, 0, 0, DW'(i * 'h11), "refill");
      step(1, 1, 0, 'h99, "simul.full");
      check("simul.full.head", data_out, 'h22);
      for (int i = 0; i < 3; i++) step(0, 1, 0, '0, "simul.drain");
      check("simul.last", data_out, 'h99);
      step(0, 1, 0, '0, "simul.drain_last");
      for (int i = 0; i < 3; i++) step(0, 1, 0, '0, "underflow");
      step(1, 0, 0, 'hC1, "clear.pre1");
      step(1, 0, 0, 'hC2, "clear.pre2");
      step(1, 0, 1, 'hC3, "clear");
      check("clear.empty_const", DW'(empty), 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 'hD0 + DW'(i), "rst.pre");
      #2 rst_n = 1'b0;
      model_q.delete();
      #1 check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 'hE1, "rst.first_push");
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom, "rand");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
